// File: rtl/alu_pkg.sv
// Shared opcode encoding and default sizing for the registered ALU.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;
  localparam int unsigned ALU_DEPTH = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: result plus carry, zero and overflow for the next register load.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned DEPTH = ALU_DEPTH
) (
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [DEPTH-1:0] opcode,
  output logic [WIDTH-1:0] y_next,
  output logic             carry_next,
  output logic             zero_next,
  output logic             overflow_next
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           hit;

  always_comb begin
    sum           = {1'b0, operand_a} + {1'b0, operand_b};
    diff          = {1'b0, operand_a} - {1'b0, operand_b};
    y_next        = '0;
    carry_next    = 1'b0;
    overflow_next = 1'b0;
    hit           = 1'b1;
    case (opcode)
      OP_ADD: begin
        y_next        = sum[WIDTH-1:0];
        carry_next    = sum[WIDTH];
        overflow_next = (operand_a[MSB] == operand_b[MSB]) && (sum[MSB] != operand_a[MSB]);
      end
      OP_SUB: begin
        // the extra bit of the widened subtraction is the unsigned borrow
        y_next        = diff[WIDTH-1:0];
        carry_next    = diff[WIDTH];
        overflow_next = (operand_a[MSB] != operand_b[MSB]) && (diff[MSB] != operand_a[MSB]);
      end
      OP_AND: y_next = operand_a & operand_b;
      OP_OR:  y_next = operand_a | operand_b;
      OP_XOR: y_next = operand_a ^ operand_b;
      OP_NOT: y_next = ~operand_a;
      OP_SHL: begin
        y_next     = {operand_a[WIDTH-2:0], 1'b0};
        carry_next = operand_a[MSB];
      end
      OP_SHR: begin
        y_next     = {1'b0, operand_a[WIDTH-1:1]};
        carry_next = operand_a[0];
      end
      default: hit = 1'b0;
    endcase
    // an unmatched opcode reports all flags clear, including zero
    zero_next = hit && (y_next == '0);
  end

endmodule

// File: rtl/alu_core_reg.sv
// Integer ALU with a single asynchronously-reset output register stage.
module alu_core_reg
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned DEPTH = ALU_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [DEPTH-1:0] opcode,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] y_d, y_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;

  alu_comb #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_alu_comb (
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .opcode       (opcode),
    .y_next       (y_d),
    .carry_next   (carry_d),
    .zero_next    (zero_d),
    .overflow_next(overflow_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q        <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      y_q        <= y_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign y        = y_q;
  assign carry    = carry_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_core_reg.sv
// Scoreboard bench for alu_core_reg: directed vectors with hand-computed results.
module tb_alu_core_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] operand_a = '0;
  logic [7:0] operand_b = '0;
  logic [2:0] opcode = '0;
  logic [7:0] y;
  logic       carry, zero, overflow;

  logic       issue = 1'b0;

  typedef struct {
    logic [7:0] y;
    logic       c;
    logic       z;
    logic       v;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  alu_core_reg #(
    .WIDTH(8),
    .DEPTH(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .opcode   (opcode),
    .y        (y),
    .carry    (carry),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] ey, input logic ec,
                       input logic ez, input logic ev);
    n_total++;
    if (y === ey && carry === ec && zero === ez && overflow === ev) n_pass++;
    else $display("FAIL %s: got y=%02h c=%0b z=%0b v=%0b, expected y=%02h c=%0b z=%0b v=%0b",
                  name, y, carry, zero, overflow, ey, ec, ez, ev);
  endtask

  // Drive one vector on the falling edge, then disturb the operands after it is captured.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [7:0] ey, input logic ec, input logic ez, input logic ev,
                       input string name);
    exp_t e;
    @(negedge clk);
    operand_a = a;
    operand_b = b;
    opcode    = op;
    issue     = 1'b1;
    e.y = ey; e.c = ec; e.z = ez; e.v = ev; e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    operand_a = 8'($urandom);
    operand_b = 8'($urandom);
  endtask

  // Monitor: any edge that captured an issued vector is compared against the queue head.
  initial begin
    logic sampled;
    exp_t e;
    forever begin
      @(posedge clk);
      sampled = issue;
      #1;
      if (sampled) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard_underflow: got a result, expected none pending");
        end else begin
          e = exp_q.pop_front();
          check(e.name, e.y, e.c, e.z, e.v);
          #3;
          check({e.name, "_hold"}, e.y, e.c, e.z, e.v);
        end
      end
    end
  end

  initial begin
    #2;
    check("reset_initial", 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("reset_held_initial", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // ops: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 NOT 6 SHL 7 SHR
    drive(8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, "add_wrap");
    drive(8'hC8, 8'h64, 3'd0, 8'h2C, 1'b1, 1'b0, 1'b0, "add_carry");
    drive(8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1, "add_ovf");
    drive(8'h05, 8'h05, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0, "sub_zero");
    drive(8'h03, 8'h05, 3'd1, 8'hFE, 1'b1, 1'b0, 1'b0, "sub_borrow");
    drive(8'h80, 8'h01, 3'd1, 8'h7F, 1'b0, 1'b0, 1'b1, "sub_ovf");
    drive(8'hF0, 8'h0F, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0, "and");
    drive(8'hF0, 8'h0F, 3'd3, 8'hFF, 1'b0, 1'b0, 1'b0, "or");
    drive(8'hAA, 8'hFF, 3'd4, 8'h55, 1'b0, 1'b0, 1'b0, "xor");
    drive(8'hFF, 8'h12, 3'd5, 8'h00, 1'b0, 1'b1, 1'b0, "not");
    drive(8'h81, 8'hFF, 3'd6, 8'h02, 1'b1, 1'b0, 1'b0, "shl");
    drive(8'h01, 8'hFF, 3'd7, 8'h00, 1'b1, 1'b1, 1'b0, "shr_zero");
    drive(8'h81, 8'h00, 3'd7, 8'h40, 1'b1, 1'b0, 1'b0, "shr");

    // Mid-stream asynchronous reset while outputs are nonzero.
    @(negedge clk);
    issue = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("reset_async", 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset_held", 8'h00, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back burst, a different opcode every cycle.
    drive(8'h01, 8'h02, 3'd0, 8'h03, 1'b0, 1'b0, 1'b0, "burst_add");
    drive(8'h10, 8'h01, 3'd1, 8'h0F, 1'b0, 1'b0, 1'b0, "burst_sub");
    drive(8'h3C, 8'h0F, 3'd2, 8'h0C, 1'b0, 1'b0, 1'b0, "burst_and");
    drive(8'h30, 8'h03, 3'd3, 8'h33, 1'b0, 1'b0, 1'b0, "burst_or");
    drive(8'h0F, 8'h0F, 3'd4, 8'h00, 1'b0, 1'b1, 1'b0, "burst_xor");
    drive(8'h5A, 8'h00, 3'd5, 8'hA5, 1'b0, 1'b0, 1'b0, "burst_not");
    drive(8'h40, 8'h00, 3'd6, 8'h80, 1'b0, 1'b0, 1'b0, "burst_shl");
    drive(8'h02, 8'h00, 3'd7, 8'h01, 1'b0, 1'b0, 1'b0, "burst_shr");

    @(negedge clk);
    issue = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #5;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_core_reg.md
Name: alu_core_reg

Overview:
- Parameterised integer ALU with one registered output stage.
- Takes two WIDTH-bit operands and a DEPTH-bit opcode, and computes one of eight arithmetic, logic or shift operations.
- Registers the result together with carry, zero and overflow flags.
- Sits behind the ALU interface's slave side. Stimulus is driven and results are sampled on posedge clk.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).
- DEPTH, 3, opcode width in bits. Fixed at 3 for the eight defined operations.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- operand_a  input  WIDTH  first operand (A).
- operand_b  input  WIDTH  second operand (B).
- opcode  input  DEPTH  operation select.
- y  output  WIDTH  registered result.
- carry  output  1  registered carry/borrow/shifted-out bit.
- zero  output  1  registered flag: y equals 0.
- overflow  output  1  registered signed two's-complement overflow.

Behaviour:
- Reset:
  - rst high asynchronously forces y=0, carry=0, zero=0, overflow=0, regardless of clk.
  - While rst is high, outputs hold these values.
  - The first capture occurs on the first rising clk edge after rst deasserts.
- Latency:
  - Inputs sampled at rising edge N appear on the outputs after edge N and hold until edge N+1.
  - One-cycle latency, full throughput, no handshake; a new operation is accepted every cycle.
- Opcodes:
  - 000 ADD: y = A + B. carry = bit WIDTH of the (WIDTH+1)-bit sum. overflow = (A[msb]==B[msb]) && (y[msb]!=A[msb]).
  - 001 SUB: y = A - B (mod 2^WIDTH). carry = borrow, i.e. 1 when A < B unsigned. overflow = (A[msb]!=B[msb]) && (y[msb]!=A[msb]).
  - 010 AND: y = A & B.
  - 011 OR: y = A | B.
  - 100 XOR: y = A ^ B.
  - 101 NOT: y = ~A; B is ignored.
  - 110 SHL: y = A << 1, LSB filled with 0. carry = A[msb].
  - 111 SHR: y = A >> 1 (logical), MSB filled with 0. carry = A[0].
- Flags outside their defining ops:
  - carry = 0 for ops 010..101.
  - overflow = 0 for every op except ADD and SUB.
- zero flag:
  - zero = (next y == 0), computed from the same result being registered, for all opcodes.
- Boundary conditions:
  - Wrap-around is modulo 2^WIDTH; no saturation.
  - X/unknown opcode is not expected. Any opcode value not matched (none exist at DEPTH=3) yields y=0 with all flags 0.
  - Operand changes between edges have no effect on outputs until the next edge.

Decomposition:
- Package alu_pkg:
  - Enum typedef alu_op_e {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR}, encoded 0..7.
  - Default WIDTH/DEPTH localparams.
- One combinational sub-module, alu_comb:
  - Computes y_next, carry_next, zero_next and overflow_next from operand_a, operand_b and opcode.
- Top alu_core_reg:
  - Instantiates alu_comb.
  - Holds the async-reset output register stage.

Test Plan:
1. Reset: assert rst mid-stream with outputs nonzero -> y, carry, zero and overflow go to 0 immediately (before any clk edge) and stay 0 while rst is high.
2. ADD:
   - A=200 (0xC8), B=100 (0x64) -> next cycle y=0x2C, carry=1, overflow=0, zero=0.
   - A=0x7F, B=0x01 -> y=0x80, carry=0, overflow=1.
3. SUB:
   - A=5, B=5 -> y=0x00, zero=1, carry=0, overflow=0.
   - A=3, B=5 -> y=0xFE, carry=1.
   - A=0x80, B=0x01 -> y=0x7F, overflow=1, carry=0.
4. Logic:
   - AND 0xF0&0x0F -> y=0x00, zero=1, carry=0.
   - OR 0xF0|0x0F -> y=0xFF.
   - XOR 0xAA^0xFF -> y=0x55.
   - NOT A=0xFF -> y=0x00, zero=1.
5. Shifts:
   - SHL A=0x81 -> y=0x02, carry=1.
   - SHR A=0x81 -> y=0x40, carry=1.
   - SHR A=0x01 -> y=0x00, zero=1, carry=1.
6. Latency/throughput: apply a different opcode on each of 8 consecutive cycles -> each result appears exactly one edge after its inputs are sampled, with no dropped or repeated results.
